// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input combination of an N_IN-input
// Boolean function, samples f_in after a settle delay, builds the minterm
// mask and compares it against a latched expected mask.
// Optional macro GRAY_ORDER_EN: present combinations in Gray-code order
// (results are still indexed by the binary value presented on stim).

module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterms,
  output logic [N_IN:0]        ones_count,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam int NCOMB = 2**N_IN;
  // settle counter counts 0..SETTLE-1 while in HOLD
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCOMB-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]    stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NCOMB-1:0]   minterms_q, minterms_d;
  logic [N_IN:0]      ones_q, ones_d;
  logic               mism_q, mism_d;
  logic [N_IN-1:0]    ferr_q, ferr_d;

  // Presentation order of the sweep: binary by default, Gray when enabled.
  function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] i);
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  function automatic logic [N_IN:0] popcount(input logic [NCOMB-1:0] m);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < NCOMB; i++) c = c + {{N_IN{1'b0}}, m[i]};
    return c;
  endfunction

  // Lowest set bit of the difference vector; 0 when nothing differs.
  function automatic logic [N_IN-1:0] lowest_set(input logic [NCOMB-1:0] d);
    logic [N_IN-1:0] r;
    r = '0;
    for (int i = NCOMB - 1; i >= 0; i--) begin
      if (d[i]) r = N_IN'(i);
    end
    return r;
  endfunction

  // Next-state and result computation for the sweep sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = done_q;
    minterms_d = minterms_q;
    ones_d     = ones_q;
    mism_d     = mism_q;
    ferr_d     = ferr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d      = expected;
          minterms_d = '0;
          ones_d     = '0;
          mism_d     = 1'b0;
          ferr_d     = '0;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          stim_d     = order('0);
          state_d    = (SETTLE == 0) ? SAMPLE : HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        minterms_d[stim_q] = f_in;
        if (idx_q == '1) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ones_d  = popcount(minterms_d);
          mism_d  = (minterms_d != exp_q);
          ferr_d  = lowest_set(minterms_d ^ exp_q);
        end else begin
          idx_d   = idx_q + 1'b1;
          stim_d  = order(idx_q + 1'b1);
          cnt_d   = '0;
          state_d = (SETTLE == 0) ? SAMPLE : HOLD;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      minterms_q <= '0;
      ones_q     <= '0;
      mism_q     <= 1'b0;
      ferr_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      minterms_q <= minterms_d;
      ones_q     <= ones_d;
      mism_q     <= mism_d;
      ferr_q     <= ferr_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign minterms      = minterms_q;
  assign ones_count    = ones_q;
  assign mismatch      = mism_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper (N_IN=3, SETTLE=1): table-driven sweeps,
// randomized functions against a reference model, and start/reset corner cases.

module tb_truth_table_sweeper;

  localparam int N  = 3;
  localparam int S  = 1;
  localparam int NC = 8;
  localparam int DONE_CYC = NC * (S + 1) + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   expected;
  logic         f_in;
  logic [2:0]   stim;
  logic         busy;
  logic         done;
  logic [7:0]   minterms;
  logic [3:0]   ones_count;
  logic         mismatch;
  logic [2:0]   first_err_idx;

  logic [7:0]   func_mask;

  int checks   = 0;
  int failures = 0;

  // Function under test: a combinational truth table indexed by stim.
  assign f_in = func_mask[stim];

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(N), .SETTLE(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .expected      (expected),
    .f_in          (f_in),
    .stim          (stim),
    .busy          (busy),
    .done          (done),
    .minterms      (minterms),
    .ones_count    (ones_count),
    .mismatch      (mismatch),
    .first_err_idx (first_err_idx)
  );

  typedef struct {
    logic [7:0] fmask;
    logic [7:0] exp;
    logic       poke;
    logic [7:0] min_e;
    logic [3:0] ones_e;
    logic       mism_e;
    logic [2:0] ferr_e;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2:0] order(input int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef GRAY_ORDER_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one sweep: start is high before edge 0, cycle k follows edge k-1.
  task automatic applyStimulus(input logic [7:0] fm, input logic [7:0] ex, input logic poke,
                               output int done_cyc, output logic seq_ok);
    int cyc;
    func_mask = fm;
    expected  = ex;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    seq_ok   = 1'b1;
    while (cyc <= 80 && done_cyc < 0) begin
      if (done) begin
        done_cyc = cyc;
      end else if (cyc < DONE_CYC) begin
        if (stim !== order((cyc - 1) / (S + 1)) || busy !== 1'b1) seq_ok = 1'b0;
      end
      if (cyc == 3) expected = ~ex;
      start = (poke && (cyc == 5 || cyc == 12)) ? 1'b1 : 1'b0;
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkSweep(input string tag, input logic [7:0] fm, input logic [7:0] ex,
                            input logic poke, input logic [7:0] min_e, input logic [3:0] ones_e,
                            input logic mism_e, input logic [2:0] ferr_e);
    int   dc;
    logic ok;
    applyStimulus(fm, ex, poke, dc, ok);
    checkOutput({tag, " done_cycle"}, 32'(dc), 32'(DONE_CYC));
    checkOutput({tag, " stim_seq"}, 32'(ok), 32'd1);
    checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, " minterms"}, 32'(minterms), 32'(min_e));
    checkOutput({tag, " ones_count"}, 32'(ones_count), 32'(ones_e));
    checkOutput({tag, " mismatch"}, 32'(mismatch), 32'(mism_e));
    checkOutput({tag, " first_err_idx"}, 32'(first_err_idx), 32'(ferr_e));
    tick();
    checkOutput({tag, " done_single"}, 32'(done), 32'd0);
    tick();
    checkOutput({tag, " result_hold"}, 32'(minterms), 32'(min_e));
    checkOutput({tag, " stim_last"}, 32'(stim), 32'(order(NC - 1)));
  endtask

  initial begin
    int   done_seen;
    int   dq[$];
    logic [7:0] fm, ex, rm;
    logic [3:0] rones;
    logic       rmism;
    logic [2:0] rferr;
    logic       found;

    vecs[0] = '{8'hAC, 8'hAC, 1'b0, 8'hAC, 4'd4, 1'b0, 3'd0};
    vecs[1] = '{8'hAC, 8'hAE, 1'b0, 8'hAC, 4'd4, 1'b1, 3'd1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 4'd8, 1'b0, 3'd0};
    vecs[4] = '{8'hAC, 8'hAC, 1'b1, 8'hAC, 4'd4, 1'b0, 3'd0};
    vecs[5] = '{8'h01, 8'h80, 1'b0, 8'h01, 4'd1, 1'b1, 3'd0};

    reset     = 1'b1;
    start     = 1'b0;
    expected  = 8'h00;
    func_mask = 8'h00;
    tick();
    tick();
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst stim", 32'(stim), 32'd0);
    checkOutput("rst minterms", 32'(minterms), 32'd0);
    checkOutput("rst ones", 32'(ones_count), 32'd0);
    checkOutput("rst mismatch", 32'(mismatch), 32'd0);
    checkOutput("rst ferr", 32'(first_err_idx), 32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      checkSweep($sformatf("vec%0d", v), vecs[v].fmask, vecs[v].exp, vecs[v].poke,
                 vecs[v].min_e, vecs[v].ones_e, vecs[v].mism_e, vecs[v].ferr_e);
    end

    // Randomized functions against a truth-table reference model.
    for (int r = 0; r < 6; r++) begin
      fm = 8'($urandom);
      ex = (r % 2 == 0) ? fm : 8'($urandom);
      rm = fm;
      rones = 4'd0;
      for (int i = 0; i < NC; i++) rones = rones + 4'(rm[i]);
      rmism = (rm != ex);
      rferr = 3'd0;
      found = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (!found && rm[i] != ex[i]) begin
          rferr = 3'(i);
          found = 1'b1;
        end
      end
      checkSweep($sformatf("rnd%0d", r), fm, ex, 1'b0, rm, rones, rmism, rferr);
    end

    // start held high for 20 cycles: back-to-back sweeps.
    func_mask = 8'hAC;
    expected  = 8'hAC;
    start     = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done) dq.push_back(cyc);
      if (cyc == 19) begin
        checkOutput("hold busy_restart", 32'(busy), 32'd1);
        checkOutput("hold stim_restart", 32'(stim), 32'(order(0)));
      end
      start = (cyc < 20) ? 1'b1 : 1'b0;
      tick();
    end
    checkOutput("hold done_count", 32'(dq.size()), 32'd2);
    if (dq.size() == 2) begin
      checkOutput("hold done1_cycle", 32'(dq[0]), 32'(DONE_CYC));
      checkOutput("hold done2_cycle", 32'(dq[1]), 32'(2 * DONE_CYC + 1));
    end
    checkOutput("hold minterms", 32'(minterms), 32'hAC);

    // Reset asserted in cycle 6 of a sweep.
    func_mask = 8'hFF;
    expected  = 8'hFF;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 6; cyc++) tick();
    checkOutput("mid busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid busy", 32'(busy), 32'd0);
    checkOutput("mid stim", 32'(stim), 32'd0);
    checkOutput("mid minterms", 32'(minterms), 32'd0);
    checkOutput("mid done", 32'(done), 32'd0);
    done_seen = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done) done_seen++;
      tick();
    end
    checkOutput("mid no_done", 32'(done_seen), 32'd0);
    checkSweep("after_rst", 8'hAC, 8'hAC, 1'b0, 8'hAC, 4'd4, 1'b0, 3'd0);

    // Reset and start in the same cycle: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rst_prio busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
